// File: rtl/regfile_8x16_onehot.sv
// 8 x DATA_W register file for the multicycle 16-bit RISC-V datapath.
// The write address arrives already decoded as a one-hot strobe. Two read
// ports capture into the A/B operand latches between decode and execute.
// Register 0 can be hardwired to zero. Strobes with more than one bit set
// never write and raise a sticky error flag.
module regfile_8x16_onehot #(
   parameter int DATA_W   = 16,
   parameter bit ZERO_REG = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        wr_onehot,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [2:0]        rd_addr_a,
   input  logic [2:0]        rd_addr_b,
   output logic [DATA_W-1:0] a_out,
   output logic [DATA_W-1:0] b_out,
   output logic              onehot_err,
   output logic              wr_done
);

   logic [DATA_W-1:0] regs     [8];
   logic [DATA_W-1:0] reg_next [8];
   logic [3:0]        wr_cnt;
   logic              wr_single;
   logic              wr_multi;
   logic [7:0]        wr_en;

   // Count the strobe bits so malformed strobes can be rejected.
   always_comb begin
      wr_cnt = '0;
      for (int i = 0; i < 8; i++) begin
         wr_cnt = wr_cnt + {3'b000, wr_onehot[i]};
      end
   end

   assign wr_single = (wr_cnt == 4'd1);
   assign wr_multi  = (wr_cnt >= 4'd2);

   // Per-register write enables. Writes to a hardwired x0 are still accepted
   // (wr_done pulses) but they never reach storage.
   always_comb begin
      wr_en = '0;
      for (int i = 0; i < 8; i++) begin
         wr_en[i] = wr_single && wr_onehot[i] && !(ZERO_REG && (i == 0));
      end
   end

   // Post-edge contents of every register. Reading this view gives the
   // write-first bypass. A hardwired x0 always reads as zero.
   always_comb begin
      for (int i = 0; i < 8; i++) begin
         reg_next[i] = regs[i];
         if (wr_en[i]) begin
            reg_next[i] = wr_data;
         end
         if (ZERO_REG && (i == 0)) begin
            reg_next[i] = '0;
         end
      end
   end

   // Register storage. Only the decoded enable can modify an entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) begin
            regs[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 8; i++) begin
            if (wr_en[i]) begin
               regs[i] <= wr_data;
            end
         end
      end
   end

   // A/B operand latches. They capture on rd_en and hold otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_out <= '0;
         b_out <= '0;
      end else if (rd_en) begin
         a_out <= reg_next[rd_addr_a];
         b_out <= reg_next[rd_addr_b];
      end
   end

   // Status: a sticky malformed-strobe flag, and a done pulse for each accepted write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         onehot_err <= 1'b0;
         wr_done    <= 1'b0;
      end else begin
         if (wr_multi) begin
            onehot_err <= 1'b1;
         end
         wr_done <= wr_single;
      end
   end

endmodule

// File: doc/regfile_8x16_onehot.md
Name: regfile_8x16_onehot

Overview:
- 8-entry × 16-bit register file for the multicycle 16-bit RISC-V datapath.
- Sits directly downstream of the 3-to-8 write-address decoder and consumes its one-hot output as the per-register write strobe.
- Provides two registered read ports that act as the A/B operand latches between the decode and execute cycles.
- Enforces x0 = 0 and flags malformed (non-one-hot) write strobes.

Parameters:
- DATA_W, 16, register and port data width.
- ZERO_REG, 1, when 1 register 0 is hardwired to zero and writes to it are discarded; when 0 it is an ordinary register.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- wr_onehot  input  8  one-hot write strobe from the decoder; all-zero means no write.
- wr_data  input  DATA_W  write-back data.
- rd_en  input  1  capture enable for the A/B operand latches.
- rd_addr_a  input  3  read address, port A.
- rd_addr_b  input  3  read address, port B.
- a_out  output  DATA_W  latched operand A.
- b_out  output  DATA_W  latched operand B.
- onehot_err  output  1  sticky flag: a write strobe with more than one bit set was seen.
- wr_done  output  1  one-cycle pulse the cycle after a write is accepted.

Behaviour:
- Reset (rst_n low, asynchronous, acts immediately):
  - All 8 registers clear to 0.
  - a_out, b_out, onehot_err and wr_done clear to 0.
  - Reset asserted mid-write discards the write. The first rising edge after deassertion operates normally.
- Write acceptance, evaluated at each rising edge:
  - Popcount(wr_onehot) = 0: no write, no error.
  - Popcount = 1 with bit k set: reg[k] <= wr_data.
    - If ZERO_REG = 1 and k = 0, the write is discarded. reg[0] stays 0, but wr_done still pulses.
  - Popcount ≥ 2: no register is modified and onehot_err is set. It stays set until reset; there is no other clear path.
- wr_done:
  - Registered; high for exactly one cycle following each edge where popcount = 1.
  - Back-to-back accepted writes keep it high continuously.
- Read, 1-cycle latency:
  - On a rising edge with rd_en = 1: a_out <= value(rd_addr_a) and b_out <= value(rd_addr_b).
  - With rd_en = 0, a_out and b_out hold.
- value(n) definition:
  - If ZERO_REG = 1 and n = 0: value is 0.
  - Else, if the same edge carries an accepted write to register n: value is wr_data (write-first bypass).
  - Else: value is the current reg[n].
- Malformed strobe and reads:
  - A malformed strobe (popcount ≥ 2) never bypasses.
  - Reads on that edge return the old register contents.
- Port independence:
  - Both ports may address the same register; both then return identical values.
  - Read and write on the same edge are fully independent apart from the bypass.
- Register contents are visible only through a_out and b_out; there is no combinational read path.
- All state changes on the rising clock edge only, except the asynchronous reset.
- No X propagation: the all-zero strobe is the idle state, and any undefined input pattern is treated per the popcount rules above.

Test Plan:
- Reset then read: release rst_n; rd_en = 1, rd_addr_a = 3, rd_addr_b = 7 -> next cycle a_out = 0x0000, b_out = 0x0000, onehot_err = 0.
- Single write then read:
  - wr_onehot = 8'b0010_0000, wr_data = 0xBEEF -> wr_done = 1 for exactly one cycle.
  - Then rd_en = 1, rd_addr_a = 5 -> a_out = 0xBEEF.
- Write-first bypass:
  - Same edge: wr_onehot = 8'b0000_0100, wr_data = 0x1234, rd_en = 1, rd_addr_a = 2, rd_addr_b = 2 -> next cycle a_out = b_out = 0x1234.
  - With rd_en = 0 the outputs hold their previous values.
- x0 protection (ZERO_REG = 1):
  - wr_onehot = 8'b0000_0001, wr_data = 0xFFFF -> wr_done pulses.
  - Subsequent read of address 0 -> 0x0000.
  - Same-edge read of address 0 -> 0x0000 (no bypass).
- Malformed strobe:
  - Preload reg1 = 0x0011 and reg3 = 0x0033.
  - wr_onehot = 8'b0000_1010, wr_data = 0xAAAA -> onehot_err = 1 and wr_done = 0; reads of 1 and 3 return 0x0011 and 0x0033.
  - onehot_err stays 1 through 10 further valid writes and clears only on rst_n low.
- Async reset mid-operation:
  - Write 0x5555 to reg6, then assert rst_n between clock edges -> a_out, b_out, onehot_err and wr_done go 0 immediately.
  - After release, a read of reg6 returns 0x0000.
